// File: rtl/issue_pkg.sv
// Shared types and sizing helpers for the issue-select arbitration blocks.
package issue_pkg;

  typedef enum logic {
    SEL_NORMAL = 1'b0,
    SEL_FORCE  = 1'b1
  } sel_state_t;

  localparam int DEFAULT_STARVE_LIMIT = 15;

  // A lone requester still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/select_lowest_pick.sv
// Combinational lowest-set-bit pick: one-hot winner, its binary index, and any-request.
module select_lowest_pick
  import issue_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot = N'(1) << i;
        idx    = IDX_W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/select_starve_arbiter.sv
// Fixed-priority arbiter with per-requester age counters; a starved requester
// is promoted for one forced-grant window. Grants are gated by the next stage.
module select_starve_arbiter
  import issue_pkg::*;
#(
  parameter int NUM_REQ      = 16,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  // Derived widths; leave at their defaults.
  parameter int CNT_W        = cnt_width(STARVE_LIMIT),
  parameter int IDX_W        = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o,
  output logic               req_o,
  output logic               force_o
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(STARVE_LIMIT);

  sel_state_t         state_q, state_d;
  logic [IDX_W-1:0]   lock_q, lock_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];

  logic [NUM_REQ-1:0] pick_oh, cand_oh;
  logic [IDX_W-1:0]   pick_idx, cand_idx, sat_idx;
  logic               lock_hit, grant_en, sat_any;

  select_lowest_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_i),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (req_o)
  );

  // The locked requester overrides the priority pick only while it still asks.
  assign lock_hit = (state_q == SEL_FORCE) && req_i[lock_q];
  assign cand_oh  = lock_hit ? (NUM_REQ'(1) << lock_q) : pick_oh;
  assign cand_idx = lock_hit ? lock_q : pick_idx;

  // Reset and flush both suppress grants in the current cycle.
  assign grant_en      = reset && grant_i && !flush_i;
  assign grant_o       = cand_oh & {NUM_REQ{grant_en}};
  assign grant_valid_o = |grant_o;
  assign grant_idx_o   = grant_valid_o ? cand_idx : '0;
  assign force_o       = (state_q == SEL_FORCE);

  // Ageing only counts opportunities the stage could actually have granted.
  always_comb begin
    sat_any = 1'b0;
    sat_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!req_i[k] || grant_o[k]) begin
        cnt_d[k] = '0;
      end else if (grant_i && (cnt_q[k] != SAT)) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
      if ((cnt_d[k] == SAT) && !sat_any) begin
        sat_any = 1'b1;
        sat_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      SEL_NORMAL: begin
        if (sat_any) begin
          state_d = SEL_FORCE;
          lock_d  = sat_idx;
        end
      end
      SEL_FORCE: begin
        if (!req_i[lock_q] || grant_o[lock_q]) state_d = SEL_NORMAL;
      end
      default: state_d = SEL_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: cnt_q is a small bank of flops, not a RAM, so every entry is reset.
      state_q <= SEL_NORMAL;
      lock_q  <= '0;
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
    end else if (flush_i) begin
      state_q <= SEL_NORMAL;
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      lock_q  <= lock_d;
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= cnt_d[k];
    end
  end

endmodule

// File: tb/tb_select_starve_arbiter.sv
// Directed bench for select_starve_arbiter with NUM_REQ=4, STARVE_LIMIT=3 (plus a LIMIT=1 copy).
module tb_select_starve_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_i;
  logic       grant_i;
  logic [3:0] req_i;

  logic [3:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       grant_valid_o, req_o, force_o;

  logic [3:0] l_grant_o;
  logic [1:0] l_grant_idx_o;
  logic       l_grant_valid_o, l_req_o, l_force_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  select_starve_arbiter #(.NUM_REQ(4), .STARVE_LIMIT(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .req_i         (req_i),
    .grant_i       (grant_i),
    .grant_o       (grant_o),
    .grant_idx_o   (grant_idx_o),
    .grant_valid_o (grant_valid_o),
    .req_o         (req_o),
    .force_o       (force_o)
  );

  select_starve_arbiter #(.NUM_REQ(4), .STARVE_LIMIT(1)) dut_lim1 (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .req_i         (req_i),
    .grant_i       (grant_i),
    .grant_o       (l_grant_o),
    .grant_idx_o   (l_grant_idx_o),
    .grant_valid_o (l_grant_valid_o),
    .req_o         (l_req_o),
    .force_o       (l_force_o)
  );

  typedef struct {
    logic       fl;
    logic [3:0] req;
    logic       gi;
    logic [3:0] g;
    logic [1:0] idx;
    logic       f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic [3:0] req, input logic gi,
                              input logic [3:0] g, input logic [1:0] idx, input logic f);
    vec_t v;
    v.fl = fl; v.req = req; v.gi = gi; v.g = g; v.idx = idx; v.f = f;
    return v;
  endfunction

  function automatic void add(input logic fl, input logic [3:0] req, input logic gi,
                              input logic [3:0] g, input logic [1:0] idx, input logic f);
    vecs.push_back(mk(fl, req, gi, g, idx, f));
  endfunction

  // Drive one cycle's inputs, check the combinational outputs, then step past the edge.
  task automatic apply_check(input string tag, input vec_t v);
    req_i   = v.req;
    grant_i = v.gi;
    flush_i = v.fl;
    #1;
    check({tag, " grant_o"},       32'(grant_o),       32'(v.g));
    check({tag, " grant_idx_o"},   32'(grant_idx_o),   32'(v.idx));
    check({tag, " grant_valid_o"}, 32'(grant_valid_o), 32'(|v.g));
    check({tag, " force_o"},       32'(force_o),       32'(v.f));
    check({tag, " req_o"},         32'(req_o),         32'(|v.req));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    flush_i = 1'b0;
    grant_i = 1'b1;
    req_i   = 4'b1111;

    // Reset holds grants low while req_o still follows req_i.
    @(posedge clk);
    #1;
    check("rst grant_o",       32'(grant_o),       32'h0);
    check("rst grant_valid_o", 32'(grant_valid_o), 32'h0);
    check("rst grant_idx_o",   32'(grant_idx_o),   32'h0);
    check("rst force_o",       32'(force_o),       32'h0);
    check("rst req_o",         32'(req_o),         32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rel grant_o",     32'(grant_o),     32'h1);
    check("rel grant_idx_o", 32'(grant_idx_o), 32'h0);
    check("rel force_o",     32'(force_o),     32'h0);
    @(posedge clk);
    #1;

    // Idle cycle clears all ages; also the req_i=0 boundary.
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    // Starvation promotion.
    repeat (3) add(0, 4'b0011, 1, 4'b0001, 0, 0);
    add(0, 4'b0011, 1, 4'b0010, 1, 1);
    add(0, 4'b0011, 1, 4'b0001, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    // Stall freezes ageing, then the promotion sequence replays from scratch.
    repeat (10) add(0, 4'b0011, 0, 4'b0000, 0, 0);
    repeat (3) add(0, 4'b0011, 1, 4'b0001, 0, 0);
    add(0, 4'b0011, 1, 4'b0010, 1, 1);
    add(0, 4'b0011, 1, 4'b0001, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    // Forced requester withdraws; its age restarts from zero.
    repeat (3) add(0, 4'b0011, 1, 4'b0001, 0, 0);
    add(0, 4'b0101, 1, 4'b0001, 0, 1);
    repeat (3) add(0, 4'b0011, 1, 4'b0001, 0, 0);
    // Flush in FORCE: no grant this cycle, ages cleared afterwards.
    add(1, 4'b0011, 1, 4'b0000, 0, 1);
    repeat (3) add(0, 4'b0011, 1, 4'b0001, 0, 0);
    add(0, 4'b0011, 1, 4'b0010, 1, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    // Simultaneous saturation of 1 and 2.
    repeat (3) add(0, 4'b0111, 1, 4'b0001, 0, 0);
    add(0, 4'b0111, 1, 4'b0010, 1, 1);
    add(0, 4'b0111, 1, 4'b0001, 0, 0);
    add(0, 4'b0111, 1, 4'b0100, 2, 1);
    add(0, 4'b0111, 1, 4'b0001, 0, 0);
    add(0, 4'b0111, 1, 4'b0010, 1, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    // FORCE holds across a stall.
    repeat (3) add(0, 4'b0011, 1, 4'b0001, 0, 0);
    repeat (2) add(0, 4'b0011, 0, 4'b0000, 0, 1);
    add(0, 4'b0011, 1, 4'b0010, 1, 1);
    add(0, 4'b0011, 1, 4'b0001, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);

    foreach (vecs[i]) apply_check($sformatf("v%0d", i), vecs[i]);

    // Reset asserted mid-FORCE clears state without waiting for an edge.
    repeat (3) apply_check("pre_rst", mk(0, 4'b0011, 1, 4'b0001, 0, 0));
    #1;
    check("force_before_rst grant_o", 32'(grant_o), 32'h2);
    check("force_before_rst force_o", 32'(force_o), 32'h1);
    reset = 1'b0;
    #1;
    check("async_rst force_o", 32'(force_o), 32'h0);
    check("async_rst grant_o", 32'(grant_o), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) apply_check("post_rst", mk(0, 4'b0011, 1, 4'b0001, 0, 0));
    apply_check("post_rst_force", mk(0, 4'b0011, 1, 4'b0010, 1, 1));
    apply_check("post_rst_idle", mk(0, 4'b0000, 1, 4'b0000, 0, 0));

    // STARVE_LIMIT=1: one lost opportunity promotes on the next cycle.
    req_i   = 4'b0011;
    grant_i = 1'b1;
    flush_i = 1'b0;
    #1;
    check("lim1 c0 grant_o", 32'(l_grant_o), 32'h1);
    check("lim1 c0 force_o", 32'(l_force_o), 32'h0);
    @(posedge clk);
    #1;
    check("lim1 c1 grant_o",     32'(l_grant_o),     32'h2);
    check("lim1 c1 grant_idx_o", 32'(l_grant_idx_o), 32'h1);
    check("lim1 c1 force_o",     32'(l_force_o),     32'h1);
    @(posedge clk);
    #1;
    check("lim1 c2 grant_o", 32'(l_grant_o), 32'h1);
    check("lim1 c2 force_o", 32'(l_force_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
